// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, decoded control bundle and the bubble constant.
package pipe_pkg;

  localparam logic [5:0] ADD  = 6'b000001;
  localparam logic [5:0] SUB  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001001;
  localparam logic [5:0] LD   = 6'b100100;
  localparam logic [5:0] ST   = 6'b100101;
  localparam logic [5:0] BNE  = 6'b101000;
  localparam logic [5:0] JMP  = 6'b101101;

  typedef struct packed {
    logic [5:0] ALUmode;
    logic       RegWrite;
    logic       MEMtoReg;
    logic       MEMWrite;
    logic       MEMRead;
    logic       Branch;
    logic       is_imm;
    logic       Store_or_BNE;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the decode slot and the EX-stage load.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_is_imm,
  input  logic                  id_store_or_bne,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hazard
);

  logic uses_rs2;
  logic rd_match;

  // Immediate forms only read rs2 when they are stores or BNE.
  assign uses_rs2 = !id_is_imm | id_store_or_bne;
  assign rd_match = (ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2));
  assign hazard   = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) & rd_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and stall hold.
// Optional bubble counter enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_W       = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [5:0]            i_ALUmode,
  input  logic                  i_RegWrite,
  input  logic                  i_MEMtoReg,
  input  logic                  i_MEMWrite,
  input  logic                  i_MEMRead,
  input  logic                  i_Branch,
  input  logic                  i_is_imm,
  input  logic                  i_Store_or_BNE,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [DATA_W-1:0]     i_rs1_data,
  input  logic [DATA_W-1:0]     i_rs2_data,
  input  logic [DATA_W-1:0]     i_imm,
  input  logic [PC_W-1:0]       i_pc,
  input  logic                  i_stall,
  input  logic                  i_flush,
`ifdef ID_EX_PERF_CNT_EN
  input  logic                  i_cnt_clr,
  output logic [15:0]           o_bubble_cnt,
`endif
  output logic                  o_hazard_detected,
  output logic                  o_if_id_stall,
  output logic                  o_ex_valid,
  output logic [5:0]            o_ex_ALUmode,
  output logic                  o_ex_RegWrite,
  output logic                  o_ex_MEMtoReg,
  output logic                  o_ex_MEMWrite,
  output logic                  o_ex_MEMRead,
  output logic                  o_ex_Branch,
  output logic                  o_ex_is_imm,
  output logic                  o_ex_Store_or_BNE,
  output logic [REG_ADDR_W-1:0] o_ex_rs1,
  output logic [REG_ADDR_W-1:0] o_ex_rs2,
  output logic [REG_ADDR_W-1:0] o_ex_rd,
  output logic [DATA_W-1:0]     o_ex_rs1_data,
  output logic [DATA_W-1:0]     o_ex_rs2_data,
  output logic [DATA_W-1:0]     o_ex_imm,
  output logic [PC_W-1:0]       o_ex_pc
);

  ctrl_t                  id_ctrl;
  ctrl_t                  ex_ctrl;
  logic                   ex_valid;
  logic [REG_ADDR_W-1:0]  ex_rs1;
  logic [REG_ADDR_W-1:0]  ex_rs2;
  logic [REG_ADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]      ex_rs1_data;
  logic [DATA_W-1:0]      ex_rs2_data;
  logic [DATA_W-1:0]      ex_imm;
  logic [PC_W-1:0]        ex_pc;
  logic                   hazard;
  logic                   forced_bubble;
  logic                   clear_ex;

  assign id_ctrl = '{ALUmode:      i_ALUmode,
                     RegWrite:     i_RegWrite,
                     MEMtoReg:     i_MEMtoReg,
                     MEMWrite:     i_MEMWrite,
                     MEMRead:      i_MEMRead,
                     Branch:       i_Branch,
                     is_imm:       i_is_imm,
                     Store_or_BNE: i_Store_or_BNE};

  load_use_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_load_use_detect (
    .id_valid        (i_id_valid),
    .id_rs1          (i_rs1),
    .id_rs2          (i_rs2),
    .id_is_imm       (i_is_imm),
    .id_store_or_bne (i_Store_or_BNE),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_ctrl.MEMRead),
    .ex_rd           (ex_rd),
    .hazard          (hazard)
  );

  // Flush beats stall; stall beats hazard. An empty decode slot also clears EX
  // but is not a forced bubble.
  assign forced_bubble = i_flush | (!i_stall & hazard);
  assign clear_ex      = forced_bubble | (!i_stall & !i_id_valid);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (clear_ex) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (!i_stall) begin
      ex_valid    <= 1'b1;
      ex_ctrl     <= id_ctrl;
      ex_rs1      <= i_rs1;
      ex_rs2      <= i_rs2;
      ex_rd       <= i_rd;
      ex_rs1_data <= i_rs1_data;
      ex_rs2_data <= i_rs2_data;
      ex_imm      <= i_imm;
      ex_pc       <= i_pc;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] bubble_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bubble_cnt <= '0;
    end else if (i_cnt_clr) begin
      bubble_cnt <= '0;
    end else if (forced_bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt;
`endif

  assign o_hazard_detected = hazard;
  assign o_if_id_stall     = hazard | i_stall;

  assign o_ex_valid        = ex_valid;
  assign o_ex_ALUmode      = ex_ctrl.ALUmode;
  assign o_ex_RegWrite     = ex_ctrl.RegWrite;
  assign o_ex_MEMtoReg     = ex_ctrl.MEMtoReg;
  assign o_ex_MEMWrite     = ex_ctrl.MEMWrite;
  assign o_ex_MEMRead      = ex_ctrl.MEMRead;
  assign o_ex_Branch       = ex_ctrl.Branch;
  assign o_ex_is_imm       = ex_ctrl.is_imm;
  assign o_ex_Store_or_BNE = ex_ctrl.Store_or_BNE;
  assign o_ex_rs1          = ex_rs1;
  assign o_ex_rs2          = ex_rs2;
  assign o_ex_rd           = ex_rd;
  assign o_ex_rs1_data     = ex_rs1_data;
  assign o_ex_rs2_data     = ex_rs2_data;
  assign o_ex_imm          = ex_imm;
  assign o_ex_pc           = ex_pc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, random traffic vs. a
// behavioural pipeline model, and (with ID_EX_PERF_CNT_EN) bubble counter checks.
module tb_id_ex_stage;
  import pipe_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic        rw, m2r, mw, mr, br, imm_f, sob;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } ins_t;

  typedef struct {
    ins_t       id;
    logic       stall, flush;
    logic       exp_haz, exp_ifs;
    logic       exp_valid;
    logic [5:0] exp_op;
    logic [4:0] exp_rd;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_id_valid;
  logic [5:0] i_ALUmode;
  logic i_RegWrite, i_MEMtoReg, i_MEMWrite, i_MEMRead, i_Branch, i_is_imm, i_Store_or_BNE;
  logic [4:0] i_rs1, i_rs2, i_rd;
  logic [31:0] i_rs1_data, i_rs2_data, i_imm, i_pc;
  logic i_stall, i_flush;
  logic o_hazard_detected, o_if_id_stall, o_ex_valid;
  logic [5:0] o_ex_ALUmode;
  logic o_ex_RegWrite, o_ex_MEMtoReg, o_ex_MEMWrite, o_ex_MEMRead, o_ex_Branch, o_ex_is_imm, o_ex_Store_or_BNE;
  logic [4:0] o_ex_rs1, o_ex_rs2, o_ex_rd;
  logic [31:0] o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc;
  logic i_cnt_clr = 1'b0;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] o_bubble_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  ins_t m_ex;
  int unsigned m_cnt = 0;
  vec_t tbl[19];

  always #5 i_clk = ~i_clk;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .PC_W(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid), .i_ALUmode(i_ALUmode),
    .i_RegWrite(i_RegWrite), .i_MEMtoReg(i_MEMtoReg), .i_MEMWrite(i_MEMWrite),
    .i_MEMRead(i_MEMRead), .i_Branch(i_Branch), .i_is_imm(i_is_imm),
    .i_Store_or_BNE(i_Store_or_BNE), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
    .i_stall(i_stall), .i_flush(i_flush),
`ifdef ID_EX_PERF_CNT_EN
    .i_cnt_clr(i_cnt_clr), .o_bubble_cnt(o_bubble_cnt),
`endif
    .o_hazard_detected(o_hazard_detected), .o_if_id_stall(o_if_id_stall),
    .o_ex_valid(o_ex_valid), .o_ex_ALUmode(o_ex_ALUmode), .o_ex_RegWrite(o_ex_RegWrite),
    .o_ex_MEMtoReg(o_ex_MEMtoReg), .o_ex_MEMWrite(o_ex_MEMWrite), .o_ex_MEMRead(o_ex_MEMRead),
    .o_ex_Branch(o_ex_Branch), .o_ex_is_imm(o_ex_is_imm), .o_ex_Store_or_BNE(o_ex_Store_or_BNE),
    .o_ex_rs1(o_ex_rs1), .o_ex_rs2(o_ex_rs2), .o_ex_rd(o_ex_rd),
    .o_ex_rs1_data(o_ex_rs1_data), .o_ex_rs2_data(o_ex_rs2_data), .o_ex_imm(o_ex_imm),
    .o_ex_pc(o_ex_pc)
  );

  // Instruction builder: control bits follow from the opcode class.
  function automatic ins_t mk(input logic [5:0] op, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] pc);
    ins_t x = '0;
    x.valid = 1'b1; x.op = op; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.pc = pc;
    x.d1 = 32'h1000_0000 | 32'(rs1) | (pc << 8);
    x.d2 = 32'h2000_0000 | 32'(rs2) | (pc << 8);
    x.imm = pc ^ 32'hFFFF_ABCD;
    case (op)
      ADD, SUB: x.rw = 1'b1;
      ADDI:     begin x.rw = 1'b1; x.imm_f = 1'b1; end
      LD:       begin x.rw = 1'b1; x.m2r = 1'b1; x.mr = 1'b1; x.imm_f = 1'b1; end
      ST:       begin x.mw = 1'b1; x.imm_f = 1'b1; x.sob = 1'b1; end
      BNE:      begin x.br = 1'b1; x.sob = 1'b1; end
      JMP:      begin x.br = 1'b1; x.imm_f = 1'b1; end
      default:  ;
    endcase
    return x;
  endfunction

  function automatic vec_t mv(input ins_t id, input logic st, fl, haz, ifs, v,
                              input logic [5:0] op, input logic [4:0] rd);
    vec_t r;
    r.id = id; r.stall = st; r.flush = fl; r.exp_haz = haz; r.exp_ifs = ifs;
    r.exp_valid = v; r.exp_op = op; r.exp_rd = rd;
    return r;
  endfunction

  // A decode instruction must wait when EX holds a valid load into a nonzero
  // register that the decode instruction reads.
  function automatic logic m_hazard(input ins_t ex, input ins_t id);
    logic reads_rs2 = !id.imm_f || id.sob;
    if (!(id.valid && ex.valid && ex.mr) || ex.rd == 5'd0) return 1'b0;
    return (ex.rd == id.rs1) || (reads_rs2 && ex.rd == id.rs2);
  endfunction

  function automatic ins_t dut_ex();
    ins_t a;
    a = {o_ex_valid, o_ex_ALUmode, o_ex_RegWrite, o_ex_MEMtoReg, o_ex_MEMWrite, o_ex_MEMRead,
         o_ex_Branch, o_ex_is_imm, o_ex_Store_or_BNE, o_ex_rs1, o_ex_rs2, o_ex_rd,
         o_ex_rs1_data, o_ex_rs2_data, o_ex_imm, o_ex_pc};
    return a;
  endfunction

  task automatic drive(input ins_t x, input logic st, fl);
    i_id_valid = x.valid; i_ALUmode = x.op; i_RegWrite = x.rw; i_MEMtoReg = x.m2r;
    i_MEMWrite = x.mw; i_MEMRead = x.mr; i_Branch = x.br; i_is_imm = x.imm_f;
    i_Store_or_BNE = x.sob; i_rs1 = x.rs1; i_rs2 = x.rs2; i_rd = x.rd;
    i_rs1_data = x.d1; i_rs2_data = x.d2; i_imm = x.imm; i_pc = x.pc;
    i_stall = st; i_flush = fl;
  endtask

  task automatic chk_regs(input string name);
    ins_t a = dut_ex();
    n_vec++;
    if (a !== m_ex) begin
      n_bad++;
      $display("FAIL %s ex_regs: got %h expected %h", name, a, m_ex);
    end
`ifdef ID_EX_PERF_CNT_EN
    n_vec++;
    if (o_bubble_cnt !== 16'(m_cnt)) begin
      n_bad++;
      $display("FAIL %s bubble_cnt: got %0d expected %0d", name, o_bubble_cnt, m_cnt);
    end
`endif
  endtask

  // One pipeline cycle: drive, check combinational outputs, advance model, clock, check.
  task automatic step(input ins_t id, input logic st, fl, input string name);
    logic h;
    drive(id, st, fl);
    #1;
    h = m_hazard(m_ex, id);
    n_vec++;
    if ({o_hazard_detected, o_if_id_stall} !== {h, h | st}) begin
      n_bad++;
      $display("FAIL %s haz/ifs: got %b%b expected %b%b", name,
               o_hazard_detected, o_if_id_stall, h, h | st);
    end
    if (fl || (!st && h)) begin
      m_ex = '0;
      if (!i_cnt_clr && m_cnt < 65535) m_cnt++;
    end else if (!st) begin
      m_ex = id.valid ? id : '0;
    end
    if (i_cnt_clr) m_cnt = 0;
    @(posedge i_clk);
    #1;
    chk_regs(name);
  endtask

  initial begin
    ins_t x;
    i_rst_n = 1'b0;
    m_ex = '0;
    drive('0, 1'b0, 1'b0);

    tbl[0]  = mv(mk(ADD,  5'd3, 5'd4, 5'd5, 32'h40), 0, 0, 0, 0, 1, ADD,  5'd5);
    tbl[1]  = mv(mk(LD,   5'd1, 5'd0, 5'd7, 32'h44), 0, 0, 0, 0, 1, LD,   5'd7);
    tbl[2]  = mv(mk(ADD,  5'd7, 5'd2, 5'd8, 32'h48), 0, 0, 1, 1, 0, 6'd0, 5'd0);
    tbl[3]  = mv(mk(ADD,  5'd7, 5'd2, 5'd8, 32'h48), 0, 0, 0, 0, 1, ADD,  5'd8);
    tbl[4]  = mv(mk(LD,   5'd1, 5'd0, 5'd0, 32'h4C), 0, 0, 0, 0, 1, LD,   5'd0);
    tbl[5]  = mv(mk(ADD,  5'd0, 5'd0, 5'd9, 32'h50), 0, 0, 0, 0, 1, ADD,  5'd9);
    tbl[6]  = mv(mk(LD,   5'd1, 5'd0, 5'd7, 32'h54), 0, 0, 0, 0, 1, LD,   5'd7);
    tbl[7]  = mv(mk(ADDI, 5'd1, 5'd7, 5'd10, 32'h58), 0, 0, 0, 0, 1, ADDI, 5'd10);
    tbl[8]  = mv(mk(LD,   5'd1, 5'd0, 5'd7, 32'h5C), 0, 0, 0, 0, 1, LD,   5'd7);
    tbl[9]  = mv(mk(ST,   5'd1, 5'd7, 5'd0, 32'h60), 0, 0, 1, 1, 0, 6'd0, 5'd0);
    tbl[10] = mv(mk(ST,   5'd1, 5'd7, 5'd0, 32'h60), 0, 0, 0, 0, 1, ST,   5'd0);
    tbl[11] = mv(mk(ADD,  5'd2, 5'd3, 5'd4, 32'h64), 1, 0, 0, 1, 1, ST,   5'd0);
    tbl[12] = mv(mk(ADD,  5'd2, 5'd3, 5'd4, 32'h64), 1, 0, 0, 1, 1, ST,   5'd0);
    tbl[13] = mv(mk(ADD,  5'd2, 5'd3, 5'd4, 32'h64), 1, 0, 0, 1, 1, ST,   5'd0);
    tbl[14] = mv(mk(ADD,  5'd2, 5'd3, 5'd4, 32'h64), 1, 1, 0, 1, 0, 6'd0, 5'd0);
    x = mk(ADD, 5'd2, 5'd3, 5'd4, 32'h68); x.valid = 1'b0;
    tbl[15] = mv(x,                                  0, 0, 0, 0, 0, 6'd0, 5'd0);
    tbl[16] = mv(mk(LD,   5'd1, 5'd0, 5'd7, 32'h6C), 0, 0, 0, 0, 1, LD,   5'd7);
    tbl[17] = mv(mk(ADD,  5'd7, 5'd2, 5'd8, 32'h70), 0, 1, 1, 1, 0, 6'd0, 5'd0);
    tbl[18] = mv(mk(ADD,  5'd7, 5'd2, 5'd8, 32'h74), 0, 0, 0, 0, 1, ADD,  5'd8);

    repeat (2) @(posedge i_clk);
    #1;
    chk_regs("reset_initial");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Fill EX with live data, then pull reset mid-cycle.
    step(mk(JMP, 5'd6, 5'd6, 5'd6, 32'hDEAD_BEE0), 0, 0, "pre_reset_load");
    step(mk(LD,  5'd9, 5'd1, 5'd3, 32'hDEAD_BEE4), 0, 0, "pre_reset_load2");
    drive(mk(ADD, 5'd3, 5'd3, 5'd3, 32'h1234), 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    m_ex = '0; m_cnt = 0;
    chk_regs("async_reset");
    n_vec++;
    if ({o_hazard_detected, o_if_id_stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_reset haz/ifs: got %b%b expected 00", o_hazard_detected, o_if_id_stall);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int unsigned i = 0; i < 19; i++) begin
      string nm = $sformatf("tbl%0d", i);
      drive(tbl[i].id, tbl[i].stall, tbl[i].flush);
      #1;
      n_vec++;
      if ({o_hazard_detected, o_if_id_stall} !== {tbl[i].exp_haz, tbl[i].exp_ifs}) begin
        n_bad++;
        $display("FAIL %s pre_edge haz/ifs: got %b%b expected %b%b", nm,
                 o_hazard_detected, o_if_id_stall, tbl[i].exp_haz, tbl[i].exp_ifs);
      end
      step(tbl[i].id, tbl[i].stall, tbl[i].flush, nm);
      n_vec++;
      if ({o_ex_valid, o_ex_ALUmode, o_ex_rd} !== {tbl[i].exp_valid, tbl[i].exp_op, tbl[i].exp_rd}) begin
        n_bad++;
        $display("FAIL %s valid/op/rd: got %b/%h/%0d expected %b/%h/%0d", nm, o_ex_valid,
                 o_ex_ALUmode, o_ex_rd, tbl[i].exp_valid, tbl[i].exp_op, tbl[i].exp_rd);
      end
    end
`ifdef ID_EX_PERF_CNT_EN
    // Table forces bubbles at rows 2, 9 (hazard) and 14, 17 (flush).
    n_vec++;
    if (o_bubble_cnt !== 16'd4) begin
      n_bad++;
      $display("FAIL tbl_bubble_total: got %0d expected 4", o_bubble_cnt);
    end
`endif

    for (int unsigned i = 0; i < 600; i++) begin
      logic [5:0] ops[7] = '{ADD, SUB, ADDI, LD, LD, ST, BNE};
      ins_t r = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
      r.d1 = $urandom; r.d2 = $urandom;
      if ($urandom_range(0, 9) == 0) r.valid = 1'b0;
      i_cnt_clr = ($urandom_range(0, 49) == 0);
      step(r, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0, "rand");
    end
    i_cnt_clr = 1'b0;

`ifdef ID_EX_PERF_CNT_EN
    i_cnt_clr = 1'b1;
    step(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h80), 0, 0, "cnt_clr");
    i_cnt_clr = 1'b0;
    drive(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h84), 1'b0, 1'b1);
    repeat (65536) @(posedge i_clk);
    #1;
    m_ex = '0; m_cnt = 65535;
    chk_regs("cnt_saturate");
    step(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h88), 0, 1, "cnt_sat_more1");
    step(mk(ADD, 5'd1, 5'd2, 5'd3, 32'h8C), 0, 1, "cnt_sat_more2");
    n_vec++;
    if (o_bubble_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL cnt_stays_saturated: got %h expected ffff", o_bubble_cnt);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
